// File: rtl/flash_rom_loader.sv
// flash_rom_loader: streams LOAD_SIZE bytes from SPI flash (READ 0x03) into SRAM at boot.
// Define LOADER_CHECKSUM_EN to add a 16-bit running byte-sum output (checksum).
module flash_rom_loader #(
    parameter logic [23:0] FLASH_START = 24'h000000,
    parameter logic [20:0] SRAM_BASE   = 21'h100000,
    parameter logic [20:0] LOAD_SIZE   = 21'd65536,
    parameter int unsigned SPI_DIV     = 4,
    parameter int unsigned WR_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flash_miso,
    output logic        flash_ncs,
    output logic        flash_sck,
    output logic        flash_mosi,
    output logic        loader_act,
    output logic [20:0] loader_a,
    output logic [7:0]  loader_d,
    output logic        loader_wr,
    output logic        done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);
    typedef enum logic [3:0] {
        ST_RESET, ST_CS_SETUP, ST_CMD, ST_DATA, ST_WR_SETUP,
        ST_WR_PULSE, ST_WR_HOLD, ST_FINISH, ST_DONE
    } state_t;

    localparam logic [31:0] CMD_WORD  = {8'h03, FLASH_START};
    localparam logic [15:0] SPI_LAST  = 16'(SPI_DIV - 1);
    localparam logic [15:0] WR_LAST   = 16'(WR_CYCLES - 1);
    localparam logic [20:0] BYTE_LAST = LOAD_SIZE - 21'd1;

    state_t      state, state_nx;
    logic [15:0] cnt;
    logic        hi;
    logic [4:0]  bit_cnt;
    logic [7:0]  shift;
    logic [20:0] byte_cnt;
    logic        tick, bit_end;

    assign tick    = cnt == (state == ST_WR_PULSE ? WR_LAST : SPI_LAST);
    // a bit ends when its high phase ends; SCK then returns low
    assign bit_end = tick && hi;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= ST_RESET;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            ST_RESET:    state_nx = ST_CS_SETUP;
            ST_CS_SETUP: state_nx = tick ? ST_CMD : state;
            ST_CMD:      state_nx = (bit_end && bit_cnt == 5'd31) ? ST_DATA : state;
            ST_DATA:     state_nx = (bit_end && bit_cnt == 5'd7) ? ST_WR_SETUP : state;
            ST_WR_SETUP: state_nx = ST_WR_PULSE;
            ST_WR_PULSE: state_nx = tick ? ST_WR_HOLD : state;
            ST_WR_HOLD:  state_nx = byte_cnt == BYTE_LAST ? ST_FINISH : ST_DATA;
            ST_FINISH:   state_nx = ST_DONE;
            default:     state_nx = ST_DONE;
        endcase
    end

    always_comb begin
        flash_ncs  = state == ST_RESET || state == ST_FINISH || state == ST_DONE;
        flash_sck  = hi;
        flash_mosi = (state == ST_CS_SETUP || state == ST_CMD) && CMD_WORD[~bit_cnt];
        loader_wr  = state == ST_WR_PULSE;
        loader_act = state != ST_DONE;
        done       = state == ST_DONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            hi       <= 1'b0;
            bit_cnt  <= '0;
            shift    <= '0;
            byte_cnt <= '0;
            loader_a <= SRAM_BASE;
            loader_d <= '0;
        end else begin
            cnt <= (tick || state_nx != state) ? '0 : cnt + 16'd1;
            if ((state == ST_CMD || state == ST_DATA) && tick) begin
                hi <= ~hi;
                if (hi)
                    bit_cnt <= (state == ST_DATA && bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                if (state == ST_DATA && !hi)
                    shift <= {shift[6:0], flash_miso};
            end
            // byte is complete at the end of bit 7, so data is valid for all of WR_SETUP
            if (state == ST_DATA && state_nx == ST_WR_SETUP)
                loader_d <= shift;
            if (state == ST_WR_HOLD) begin
                byte_cnt <= byte_cnt + 21'd1;
                loader_a <= loader_a + 21'd1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            checksum <= '0;
        else if (state == ST_WR_SETUP)
            checksum <= checksum + {8'h00, loader_d};
`endif
endmodule

// File: tb/tb_flash_rom_loader.sv
// tb_flash_rom_loader: flash model + transaction-level model of the expected SRAM write stream.
module tb_flash_rom_loader;
    localparam logic [23:0] FS = 24'h0A0B0C;
    localparam logic [20:0] SB = 21'h1FFFFE;
    localparam logic [20:0] LS = 21'd4;
    localparam int SD = 2;
    localparam int WC = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic flash_miso = 1'b0;
    logic flash_ncs, flash_sck, flash_mosi, loader_act, loader_wr, done;
    logic [20:0] loader_a;
    logic [7:0] loader_d;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    flash_rom_loader #(
        .FLASH_START(FS), .SRAM_BASE(SB), .LOAD_SIZE(LS), .SPI_DIV(SD), .WR_CYCLES(WC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flash_miso(flash_miso), .flash_ncs(flash_ncs),
        .flash_sck(flash_sck), .flash_mosi(flash_mosi), .loader_act(loader_act),
        .loader_a(loader_a), .loader_d(loader_d), .loader_wr(loader_wr), .done(done)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        logic [23:0] off;
        off = a - FS;
        case (off)
            24'd0:   return 8'hA5;
            24'd1:   return 8'h3C;
            24'd2:   return 8'h00;
            24'd3:   return 8'hFF;
            default: return 8'h5A ^ a[7:0];
        endcase
    endfunction

    // flash: captures the command on rising SCK, shifts data out on falling SCK
    int rx_bits = 0;
    logic [31:0] cmd_rx = '0;
    logic [7:0] fb;

    always @(posedge flash_sck or posedge flash_ncs)
        if (flash_ncs)
            rx_bits = 0;
        else begin
            if (rx_bits < 32)
                cmd_rx = {cmd_rx[30:0], flash_mosi};
            else
                chk("mosi_idle_in_data", 32'(flash_mosi), 0);
            rx_bits++;
        end

    always @(posedge flash_sck) chk("ncs_low_at_sck_rise", 32'(flash_ncs), 0);

    always @(negedge flash_sck)
        if (!flash_ncs && rx_bits >= 32) begin
            fb = fbyte(FS + 24'((rx_bits - 32) / 8));
            flash_miso <= fb[7 - (rx_bits - 32) % 8];
        end

    // write-stream model: byte n goes to SB+n with flash byte FS+n, WC cycles wide
    int n = 0, fin = 0, wr_w = 0, hi_run = 0, pulses = 0;
    logic prev_wr = 1'b0;
    logic [20:0] prev_a;
    logic [7:0] prev_d;
    logic [7:0] sram [logic [20:0]];

    always @(negedge clk) begin
        if (!reset_n) begin
            n = 0; fin = 0; wr_w = 0; hi_run = 0; prev_wr = 1'b0;
        end else begin
            if (flash_sck)
                hi_run++;
            else if (hi_run != 0) begin
                chk("sck_high_width", hi_run, SD);
                hi_run = 0;
            end
            if (loader_wr) begin
                if (!prev_wr) begin
                    pulses++;
                    chk("wr_not_beyond_size", (n < 32'(LS)) ? 1 : 0, 1);
                    chk("a_valid_in_setup", 32'(prev_a), 32'(loader_a));
                    chk("d_valid_in_setup", 32'(prev_d), 32'(loader_d));
                    chk("wr_addr", 32'(loader_a), 32'(21'(SB + 21'(n))));
                    chk("wr_data", 32'(loader_d), 32'(fbyte(FS + 24'(n))));
                    chk("sck_rises_before_wr", rx_bits, 32 + 8 * (n + 1));
                end else begin
                    chk("a_stable_pulse", 32'(loader_a), 32'(prev_a));
                    chk("d_stable_pulse", 32'(loader_d), 32'(prev_d));
                end
                chk("sck_idle_in_wr", 32'(flash_sck), 0);
                sram[loader_a] = loader_d;
                wr_w++;
            end else if (prev_wr) begin
                chk("wr_width", wr_w, WC);
                chk("a_stable_hold", 32'(loader_a), 32'(prev_a));
                chk("d_stable_hold", 32'(loader_d), 32'(prev_d));
                chk("no_sck_in_wr", rx_bits, 32 + 8 * (n + 1));
                wr_w = 0;
                n++;
                if (n == 32'(LS)) fin = 1;
            end
            if (fin == 0 || fin == 1) begin
                chk("act_busy", 32'(loader_act), 1);
                chk("done_busy", 32'(done), 0);
                if (fin == 1) chk("ncs_low_last_hold", 32'(flash_ncs), 0);
            end else if (fin == 2) begin
                chk("ncs_finish", 32'(flash_ncs), 1);
                chk("act_finish", 32'(loader_act), 1);
                chk("done_finish", 32'(done), 0);
            end else begin
                chk("done_static",
                    32'({flash_ncs, flash_sck, loader_wr, loader_act, done}), 32'(5'b10001));
            end
            if (fin > 0) fin++;
            prev_wr = loader_wr;
            prev_a = loader_a;
            prev_d = loader_d;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_outs"},
            32'({loader_act, loader_wr, flash_ncs, flash_sck, flash_mosi, done}),
            32'(6'b101000));
        chk({tag, "_a"}, 32'(loader_a), 32'(SB));
        chk({tag, "_d"}, 32'(loader_d), 0);
`ifdef LOADER_CHECKSUM_EN
        chk({tag, "_checksum"}, 32'(checksum), 0);
`endif
    endtask

    task automatic clear_image();
        sram.delete();
        sram[21'h1FFFFE] = 8'hEE;
        sram[21'h1FFFFF] = 8'hEE;
        sram[21'h000000] = 8'hEE;
        sram[21'h000001] = 8'hEE;
        pulses = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000 && !done; i++) @(posedge clk);
        #1 chk("done_within_budget", 32'(done), 1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_image(input string tag);
        chk({tag, "_cmd"}, cmd_rx, 32'h030A0B0C);
        chk({tag, "_sram_1FFFFE"}, 32'(sram[21'h1FFFFE]), 32'h0A5);
        chk({tag, "_sram_1FFFFF"}, 32'(sram[21'h1FFFFF]), 32'h03C);
        chk({tag, "_sram_000000"}, 32'(sram[21'h000000]), 32'h000);
        chk({tag, "_sram_000001"}, 32'(sram[21'h000001]), 32'h0FF);
        chk({tag, "_pulses"}, pulses, 4);
        chk({tag, "_act_done"}, 32'({loader_act, done}), 32'(2'b01));
`ifdef LOADER_CHECKSUM_EN
        chk({tag, "_checksum"}, 32'(checksum), 32'h01E0);
`endif
    endtask

    initial begin
        clear_image();
        #1 reset_n = 1'b0;
        #2 check_reset_vals("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        wait_done();
        check_image("load1");
        @(negedge clk) reset_n = 1'b0;
        clear_image();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 5000 && n < 2; i++) @(posedge clk);
        chk("two_bytes_within_budget", n, 2);
        #1 reset_n = 1'b0;
        #1 check_reset_vals("reset_mid");
        clear_image();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        wait_done();
        check_image("reload");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
